// File: rtl/serial_bank_mapper.sv
// ============================================================================
// serial_bank_mapper - MMC1-style serially loaded PRG/CHR bank mapper
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_bank_mapper #(
    parameter int PRG_BANK_W = 4,
    parameter int CHR_BANK_W = 5
) (
    input  logic                    i_clk_cpu,
    input  logic                    i_rst,
    input  logic                    i_ce,
    input  logic                    i_rnw,
    input  logic [15:0]             i_addr,
    input  logic [7:0]              i_data_in,
    input  logic [7:0]              i_prg_rom_data,
    output logic [7:0]              o_data_out,
    output logic [PRG_BANK_W+13:0]  o_prg_rom_addr,
    input  logic [12:0]             i_ppu_addr,
    output logic [CHR_BANK_W+11:0]  o_chr_addr,
    output logic [1:0]              o_mirror,
    output logic                    o_prg_ram_en
);

    localparam logic [4:0] C_CONTROL_RST = 5'h0C;
    localparam logic [4:0] C_SHIFT_EMPTY = 5'b10000;

    logic [4:0] r_control;
    logic [4:0] r_chr0;
    logic [4:0] r_chr1;
    logic [4:0] r_prg;
    logic [4:0] r_shift;
    logic       r_prev_wr;

    logic                   w_wr;
    logic                   w_accept;
    logic [4:0]             w_shift_next;
    logic [PRG_BANK_W-1:0]  w_bank32;
    logic [PRG_BANK_W-1:0]  w_prg_bank;
    logic [CHR_BANK_W-1:0]  w_bank8;
    logic [4:0]             w_chr_sel;
    logic [CHR_BANK_W-1:0]  w_chr_bank;
    logic                   w_unused;

    assign w_wr         = i_ce & ~i_rnw;
    assign w_accept     = w_wr & ~r_prev_wr;
    assign w_shift_next = {i_data_in[0], r_shift[4:1]};

    // The marker bit reaching bit 0 means four bits are already held.
    always_ff @(posedge i_clk_cpu or posedge i_rst) begin
        if (i_rst) begin
            r_control <= C_CONTROL_RST;
            r_chr0    <= 5'd0;
            r_chr1    <= 5'd0;
            r_prg     <= 5'd0;
            r_shift   <= C_SHIFT_EMPTY;
            r_prev_wr <= 1'b0;
        end else begin
            r_prev_wr <= w_wr;
            if (w_accept) begin
                if (i_data_in[7]) begin
                    r_shift   <= C_SHIFT_EMPTY;
                    r_control <= r_control | C_CONTROL_RST;
                end else if (!r_shift[0]) begin
                    r_shift <= w_shift_next;
                end else begin
                    r_shift <= C_SHIFT_EMPTY;
                    case (i_addr[14:13])
                        2'd0:    r_control <= w_shift_next;
                        2'd1:    r_chr0    <= w_shift_next;
                        2'd2:    r_chr1    <= w_shift_next;
                        default: r_prg     <= w_shift_next;
                    endcase
                end
            end
        end
    end

    // 32KB / 8KB modes drop the bank LSB and substitute the CPU/PPU address bit.
    if (PRG_BANK_W == 1) begin : g_prg32_narrow
        assign w_bank32 = i_addr[14];
    end else begin : g_prg32_wide
        assign w_bank32 = {r_prg[PRG_BANK_W-1:1], i_addr[14]};
    end

    if (CHR_BANK_W == 1) begin : g_chr8_narrow
        assign w_bank8 = i_ppu_addr[12];
    end else begin : g_chr8_wide
        assign w_bank8 = {r_chr0[CHR_BANK_W-1:1], i_ppu_addr[12]};
    end

    always_comb begin
        w_prg_bank = '0;
        case (r_control[3:2])
            2'd0, 2'd1: w_prg_bank = w_bank32;
            2'd2:       w_prg_bank = i_addr[14] ? r_prg[PRG_BANK_W-1:0] : '0;
            default:    w_prg_bank = i_addr[14] ? '1 : r_prg[PRG_BANK_W-1:0];
        endcase
    end

    assign w_chr_sel  = i_ppu_addr[12] ? r_chr1 : r_chr0;
    assign w_chr_bank = r_control[4] ? w_chr_sel[CHR_BANK_W-1:0] : w_bank8;

    assign o_prg_rom_addr = {w_prg_bank, i_addr[13:0]};
    assign o_chr_addr     = {w_chr_bank, i_ppu_addr[11:0]};
    assign o_mirror       = r_control[1:0];
    assign o_prg_ram_en   = ~r_prg[4];
    assign o_data_out     = (i_ce & i_rnw) ? i_prg_rom_data : 8'hFF;

    assign w_unused = ^{i_addr[15], i_data_in[6:1], r_prg, r_chr0, r_chr1};

endmodule

`default_nettype wire
